// File: rtl/main_control_fsm.sv
// Multicycle main control unit: decodes the IR opcode and sequences
// fetch/decode/execute/memory/writeback, driving all datapath enables.
module main_control_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JMP    = 4'd10,
    S_AEXE   = 4'd11,
    S_AWB    = 4'd12
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = S_IDLE;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // PC step and IR load only commit on the cycle memory delivers the word
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_AEXE;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_SW)      state_d = S_MEMWR;
        else if (opcode == OP_LW) state_d = S_MEMRD;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_AEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_AWB;
      end
      S_AWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench: a per-instruction model expands each opcode into its
// expected cycle sequence; a negedge monitor compares the DUT cycle by cycle.
module tb_main_control_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  main_control_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct {
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [16:0] w;
  } rec_t;

  rec_t sched[$];
  rec_t scbd[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  logic [16:0] dut_w;
  assign dut_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, illegal};

  function automatic logic [16:0] mk(
    input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
    input logic [1:0] asb, aop, pcs, input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  task automatic push(input logic [3:0] st, input logic [16:0] w,
                      input logic mr, input logic [5:0] op);
    rec_t r;
    r.mr = mr; r.op = op; r.st = st; r.w = w;
    sched.push_back(r);
  endtask

  // Expected cycle sequence of one instruction, starting at its FETCH.
  // mem_ready outside memory-waiting cycles is random: the FSM must ignore it.
  task automatic gen_instr(input logic [5:0] op, input int stall_f, input int stall_m);
    logic any;
    repeat (stall_f) push(4'd1, mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0, op);
    push(4'd1, mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, op);
    any = 1'($urandom);
    push(4'd2, mk(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,!is_legal(op)), any, op);
    if (!is_legal(op)) return;
    case (op)
      OP_LW, OP_SW: begin
        push(4'd3, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'($urandom), op);
        if (op == OP_LW) begin
          repeat (stall_m) push(4'd4, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, op);
          push(4'd4, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, op);
          push(4'd5, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), op);
        end else begin
          repeat (stall_m) push(4'd6, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, op);
          push(4'd6, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, op);
        end
      end
      OP_RTYPE: begin
        push(4'd7, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), 1'($urandom), op);
        push(4'd8, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), op);
      end
      OP_BEQ: push(4'd9, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), 1'($urandom), op);
      OP_J:   push(4'd10, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), 1'($urandom), op);
      default: begin
        push(4'd11, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'($urandom), op);
        push(4'd12, mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), op);
      end
    endcase
  endtask

  task automatic drive_one();
    rec_t r;
    r = sched.pop_front();
    mem_ready = r.mr;
    opcode    = r.op;
    scbd.push_back(r);
  endtask

  task automatic run_all();
    while (sched.size() > 0) begin
      drive_one();
      @(posedge clock); #1;
    end
  endtask

  always @(negedge clock) begin
    rec_t e;
    if (scbd.size() > 0) begin
      e = scbd.pop_front();
      cyc++;
      n_chk++;
      if (state === e.st && dut_w === e.w) n_pass++;
      else $display("FAIL cycle%0d op=%b: got state=%0d ctl=%h, want state=%0d ctl=%h",
                    cyc, e.op, state, dut_w, e.st, e.w);
    end
  end

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_RTYPE;
      1: op = OP_LW;
      2: op = OP_SW;
      3: op = OP_BEQ;
      4: op = OP_J;
      5: op = OP_ADDI;
      default: begin
        op = 6'b111111;
        for (int k = 0; k < 20; k++) begin
          op = 6'($urandom_range(0, 63));
          if (!is_legal(op)) break;
        end
        if (is_legal(op)) op = 6'b110011;
      end
    endcase
    return op;
  endfunction

  task automatic check1(input string name, input logic [16:0] got, input logic [16:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  initial begin
    int guard;
    #3;
    check1("reset_outputs", {dut_w[16:0]} | {13'd0, state}, 17'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    push(4'd0, 17'd0, 1'b1, 6'd0);
    gen_instr(OP_RTYPE, 0, 0);
    gen_instr(OP_LW, 0, 3);
    gen_instr(OP_BEQ, 0, 0);
    gen_instr(6'b111111, 0, 0);
    gen_instr(OP_SW, 2, 1);
    gen_instr(OP_J, 1, 0);
    gen_instr(OP_ADDI, 0, 0);
    for (int i = 0; i < 60; i++)
      gen_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));
    run_all();

    // Reset in the middle of a stalled store; the DUT is now in FETCH.
    gen_instr(OP_SW, 0, 3);
    for (int i = 0; i < 3; i++) begin
      drive_one();
      @(posedge clock); #1;
    end
    drive_one();
    @(negedge clock); #1;
    check1("memwr_before_reset", {16'd0, MemWrite}, 17'd1);
    #1 reset = 1'b1;
    #1;
    check1("memwr_async_drop", {16'd0, MemWrite}, 17'd0);
    check1("state_async_reset", {13'd0, state}, 17'd0);
    sched.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    push(4'd0, 17'd0, 1'b1, 6'd0);
    gen_instr(OP_LW, 1, 1);
    gen_instr(OP_SW, 0, 0);
    run_all();

    guard = 0;
    while (scbd.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    n_chk++;
    if (scbd.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", scbd.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
